// File: rtl/fluxcore_pkg.sv
// Shared types for the fluxcore control sequencer: opcodes, FSM states, datapath width.
package fluxcore_pkg;

  localparam int N_DEF = 8;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_OUT = 4'h4,
    OP_JMP = 4'h5,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_EXEC,
    S_HALT
  } state_e;

  function automatic logic is_legal(input logic [3:0] o);
    case (o)
      OP_NOP, OP_LDI, OP_ADD, OP_SUB, OP_OUT, OP_JMP, OP_HLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational ADD/SUB for the sequencer; carry is borrow-not on SUB.
module seq_alu #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] res,
  output logic         c,
  output logic         z
);

  logic [N:0] sum;

  // a - b as a + ~b + 1, so carry-out is 1 exactly when a >= b
  assign sum = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{N{1'b0}}, sub};
  assign res = sum[N-1:0];
  assign c   = sum[N];
  assign z   = (res == '0);

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer driving the fluxcore register file.
// Build option CTRL_SEQ_ILLEGAL_TRAP_EN: illegal opcodes halt and raise illegal_op.
module control_sequencer
  import fluxcore_pkg::*;
#(
  parameter int            N        = N_DEF,
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [N-1:0]  mem_rdata,
  input  logic [N-1:0]  rega,
  input  logic [N-1:0]  regb,
  output logic          reg_write_en,
  output logic          reg_out_en,
  output logic [2:0]    reg_sel,
  output logic [N-1:0]  reg_wdata,
  output logic          out_strobe,
  output logic          flag_c,
  output logic          flag_z,
  output logic          halted,
  output logic [AW-1:0] pc
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
  ,output logic         illegal_op
`endif
);

  state_e         state, state_nx;
  logic [N-1:0]   ir, imm;
  opcode_e        op;
  logic [2:0]     rsel;
  logic [N-1:0]   alu_res;
  logic           alu_c, alu_z;
  logic           unused_ir3;

  assign op         = opcode_e'(ir[7:4]);
  assign rsel       = ir[2:0];
  assign unused_ir3 = ir[3];

  seq_alu #(.N(N)) u_alu (
    .a   (rega),
    .b   (regb),
    .sub (op == OP_SUB),
    .res (alu_res),
    .c   (alu_c),
    .z   (alu_z)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (mem_ack) state_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_NOP:                 state_nx = S_FETCH;
          OP_HLT:                 state_nx = S_HALT;
          OP_LDI, OP_JMP:         state_nx = S_IMM;
          OP_ADD, OP_SUB, OP_OUT: state_nx = S_EXEC;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
          default:                state_nx = S_HALT;
`else
          default:                state_nx = S_FETCH;
`endif
        endcase
      end
      S_IMM:    if (mem_ack) state_nx = S_EXEC;
      S_EXEC:   state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Strobes decode the registered state only; rst gates mem_req so a
  // pending fetch is dropped the moment reset is applied.
  always_comb begin
    reg_write_en = 1'b0;
    reg_out_en   = 1'b0;
    out_strobe   = 1'b0;
    reg_sel      = '0;
    reg_wdata    = '0;
    if (state == S_EXEC) begin
      case (op)
        OP_LDI: begin
          reg_write_en = 1'b1;
          reg_sel      = rsel;
          reg_wdata    = imm;
        end
        OP_ADD, OP_SUB: begin
          reg_write_en = 1'b1;
          reg_sel      = rsel;
          reg_wdata    = alu_res;
        end
        OP_OUT: begin
          reg_out_en = 1'b1;
          out_strobe = 1'b1;
          reg_sel    = rsel;
        end
        default: ;
      endcase
    end
  end

  assign mem_req  = !rst && (state == S_FETCH || state == S_IMM);
  assign mem_addr = pc;
  assign halted   = (state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      ir     <= '0;
      imm    <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (mem_ack) begin
          ir <= mem_rdata;
          pc <= pc + AW'(1);
        end
        S_IMM: if (mem_ack) begin
          imm <= mem_rdata;
          pc  <= pc + AW'(1);
        end
        S_EXEC: begin
          case (op)
            OP_ADD, OP_SUB: begin
              flag_c <= alu_c;
              flag_z <= alu_z;
            end
            OP_JMP:  pc <= AW'(imm);
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        illegal_op <= 1'b0;
    else if (state == S_DECODE && !is_legal(ir[7:4])) illegal_op <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed programs, memory and regfile models.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] rega, regb;
  logic       reg_write_en, reg_out_en, out_strobe;
  logic [2:0] reg_sel;
  logic [7:0] reg_wdata;
  logic       flag_c, flag_z, halted;
  logic [7:0] pc;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  control_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .rega         (rega),
    .regb         (regb),
    .reg_write_en (reg_write_en),
    .reg_out_en   (reg_out_en),
    .reg_sel      (reg_sel),
    .reg_wdata    (reg_wdata),
    .out_strobe   (out_strobe),
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .halted       (halted),
    .pc           (pc)
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    ,.illegal_op  (illegal_op)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_out;
    logic [2:0] sel;
    logic [7:0] wdata;
    logic [7:0] pc;
    int         cyc;
    bit         fl;
    bit         c;
    bit         z;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc;
  logic [7:0] mem [256];
  logic [7:0] regs [8];
  bit         ack_en = 1'b1;
  bit         force_ack = 1'b0;
  int         ack_delay = 0;
  int         wcnt = 0;
  bit         preload = 1'b0;
  logic [7:0] pre_a = 8'h00, pre_b = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input bit is_out, input logic [2:0] sel, input logic [7:0] wd,
                      input logic [7:0] p, input int cy, input bit fl, input bit c, input bit z);
    exp_t e;
    e.is_out = is_out; e.sel = sel; e.wdata = wd; e.pc = p;
    e.cyc = cy; e.fl = fl; e.c = c; e.z = z;
    sb.push_back(e);
  endtask

  // cycle 1 is the cycle in which reset is released
  always @(posedge clk) cyc <= rst ? 1 : cyc + 1;

  // register file: reg 0/1 feed rega/regb
  always @(posedge clk) begin
    if (preload) begin
      regs[0] <= pre_a;
      regs[1] <= pre_b;
    end else if (reg_write_en) begin
      regs[reg_sel] <= reg_wdata;
    end
  end
  assign rega = regs[0];
  assign regb = regs[1];

  // program memory; junk on rdata whenever ack is low
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 8'h12;
    forever begin
      @(negedge clk);
      if (!rst && ack_en && (mem_req || force_ack)) begin
        if (!force_ack && wcnt < ack_delay) begin
          wcnt++;
          mem_ack = 1'b0;
          mem_rdata = 8'h12;
        end else begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr];
          wcnt = 0;
        end
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 8'h12;
        if (!mem_req) wcnt = 0;
      end
    end
  end

  // monitor: pop one expectation per register-file strobe
  initial begin
    exp_t e;
    bit   pend = 1'b0;
    bit   pc_e = 1'b0, pz_e = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("flag_c", flag_c, pc_e);
        chk("flag_z", flag_z, pz_e);
        pend = 1'b0;
      end
      if (!rst && (reg_write_en || reg_out_en || out_strobe)) begin
        chk("we_oe_exclusive", reg_write_en & reg_out_en, 0);
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_strobe: we=%b oe=%b os=%b sel=%0d pc=%0h, none expected",
                   reg_write_en, reg_out_en, out_strobe, reg_sel, pc);
        end else begin
          e = sb.pop_front();
          chk("strobe_kind", {reg_write_en, reg_out_en, out_strobe},
              e.is_out ? 3'b011 : 3'b100);
          chk("reg_sel", reg_sel, e.sel);
          if (!e.is_out) chk("reg_wdata", reg_wdata, e.wdata);
          chk("exec_pc", pc, e.pc);
          if (e.cyc > 0) chk("exec_cycle", cyc, e.cyc);
          if (e.fl) begin
            pend = 1'b1; pc_e = e.c; pz_e = e.z;
          end
        end
      end
    end
  end

  task automatic release_rst();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_halt(input string nm);
    for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
    chk(nm, halted, 1);
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    chk(nm, sb.size(), 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    clear_mem();
    @(posedge clk); #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_strobes", {reg_write_en, reg_out_en, out_strobe}, 0);
    chk("rst_sel_wdata", {reg_sel, reg_wdata}, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_flags", {flag_c, flag_z}, 0);

    // ---- seg1: LDI/ADD/SUB/OUT/NOP/JMP, pc wrap, HLT ----
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h5A;   // LDI r2,5A
    mem[8'h02] = 8'h10; mem[8'h03] = 8'hF0;   // LDI r0,F0
    mem[8'h04] = 8'h11; mem[8'h05] = 8'h10;   // LDI r1,10
    mem[8'h06] = 8'h23;                       // ADD r3
    mem[8'h07] = 8'h10; mem[8'h08] = 8'h05;   // LDI r0,05
    mem[8'h09] = 8'h11; mem[8'h0A] = 8'h07;   // LDI r1,07
    mem[8'h0B] = 8'h34;                       // SUB r4
    mem[8'h0C] = 8'h44;                       // OUT r4
    mem[8'h0D] = 8'h00;                       // NOP
    mem[8'h0E] = 8'h51; mem[8'h0F] = 8'h40;   // JMP 40
    mem[8'h40] = 8'h45;                       // OUT r5
    mem[8'h41] = 8'h52; mem[8'h42] = 8'hFE;   // JMP FE
    mem[8'hFE] = 8'h16; mem[8'hFF] = 8'h77;   // LDI r6,77 -> pc wraps
    push(0, 3'd2, 8'h5A, 8'h02, 4, 0, 0, 0);
    push(0, 3'd0, 8'hF0, 8'h04, 0, 0, 0, 0);
    push(0, 3'd1, 8'h10, 8'h06, 0, 0, 0, 0);
    push(0, 3'd3, 8'h00, 8'h07, 0, 1, 1, 1);
    push(0, 3'd0, 8'h05, 8'h09, 0, 1, 1, 1);
    push(0, 3'd1, 8'h07, 8'h0B, 0, 0, 0, 0);
    push(0, 3'd4, 8'hFE, 8'h0C, 0, 1, 0, 0);
    push(1, 3'd4, 8'h00, 8'h0D, 0, 1, 0, 0);
    push(1, 3'd5, 8'h00, 8'h41, 0, 0, 0, 0);
    push(0, 3'd6, 8'h77, 8'h00, 0, 0, 0, 0);
    release_rst();
    repeat (3) @(negedge clk);
    mem[8'h00] = 8'hF0;                       // wrapped fetch hits HLT
    wait_halt("seg1_halt");
    chk("seg1_halt_pc", pc, 8'h01);
    chk("seg1_halt_req", mem_req, 0);
    chk("seg1_sb_empty", sb.size(), 0);
    repeat (4) @(negedge clk);
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("halt_sticky", halted, 1);
    chk("halt_ignores_ack_pc", pc, 8'h01);

    // ---- seg2: delayed ack, then reset during a pending fetch ----
    rst = 1'b1;
    clear_mem();
    mem[8'h00] = 8'h43;                       // OUT r3
    mem[8'h01] = 8'h22;                       // ADD r2 (FF+01)
    ack_delay = 3;
    pre_a = 8'hFF; pre_b = 8'h01; preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    push(1, 3'd3, 8'h00, 8'h01, 6, 1, 0, 0);
    push(0, 3'd2, 8'h00, 8'h02, 0, 1, 1, 1);
    release_rst();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 8'h00);
      chk("stall_strobes", {reg_write_en, reg_out_en, out_strobe}, 0);
    end
    wait_empty("seg2_sb_empty");
    ack_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("pend_req", mem_req, 1);
    chk("pend_addr", mem_addr, 8'h02);
    rst = 1'b1;
    #1;
    chk("midfetch_rst_req", mem_req, 0);
    chk("midfetch_rst_flags", {flag_c, flag_z}, 0);
    chk("midfetch_rst_pc", pc, 8'h00);
    chk("midfetch_rst_halted", halted, 0);

    // ---- seg3: illegal opcode 0x70 ----
    clear_mem();
    mem[8'h00] = 8'h70;
    mem[8'h01] = 8'h43;                       // OUT r3
    mem[8'h02] = 8'hF0;                       // HLT
    ack_en = 1'b1;
    ack_delay = 0;
`ifndef CTRL_SEQ_ILLEGAL_TRAP_EN
    push(1, 3'd3, 8'h00, 8'h02, 5, 0, 0, 0);
`endif
    repeat (2) @(posedge clk);
    release_rst();
    #1;
    chk("post_rst_addr", mem_addr, 8'h00);
    chk("post_rst_req", mem_req, 1);
    chk("post_rst_halted", halted, 0);
    wait_halt("seg3_halt");
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    chk("trap_illegal_op", illegal_op, 1);
    chk("trap_pc", pc, 8'h01);
    repeat (3) @(negedge clk);
    chk("trap_req", mem_req, 0);
    chk("trap_sticky", {halted, illegal_op}, 2'b11);
`else
    chk("illegal_nop_pc", pc, 8'h03);
    repeat (3) @(negedge clk);
    chk("hlt_req", mem_req, 0);
    chk("hlt_sticky", halted, 1);
`endif
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
